rv32_branch_predictor: RTL and testbench
========================================

RV32_BRANCH_PREDICTOR -- requirements
Module: rv32_branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, giving log2 of the branch history table (BHT) entry count (64 entries).
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port clear_in, input, 1, request to re-initialise the BHT.
REQ-005 SHALL have port lookup_valid_in, input, 1, fetch-stage lookup request.
REQ-006 SHALL have port lookup_pc_in, input, 32, PC of the instruction being fetched.
REQ-007 SHALL have port update_valid_in, input, 1, a resolved conditional branch from execute.
REQ-008 SHALL have port update_pc_in, input, 32, PC of the resolved branch.
REQ-009 SHALL have port update_taken_in, input, 1, actual branch outcome.
REQ-010 SHALL have port update_mispredicted_in, input, 1, branch-unit mispredict flag for this update.
REQ-011 SHALL have port ready_out, output, 1, high when the BHT is initialised and serving.
REQ-012 SHALL have port predicted_valid_out, output, 1, marks predicted_taken_out as valid for the previous-cycle lookup.
REQ-013 SHALL have port predicted_taken_out, output, 1, taken prediction, which drives predicted_taken_in of the branch unit.
REQ-014 SHALL have port branch_count_out, output, 32, count of accepted updates.
REQ-015 SHALL have port mispredict_count_out, output, 32, count of accepted updates that had update_mispredicted_in set.

Function
REQ-016 Each BHT entry SHALL be a 2-bit saturating counter with encodings 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; the prediction is bit 1.
REQ-017 The BHT index SHALL be pc[INDEX_BITS+1:2]; bits [1:0] and bits above the index are ignored, so aliasing is permitted.
REQ-018 The FSM SHALL have two states: INIT and READY.
REQ-019 In INIT, an index counter SHALL sweep 0 to 2^INDEX_BITS-1, writing 01 to one entry per cycle; the transition to READY occurs on the cycle after the last write.
REQ-020 ready_out SHALL be 1 only in READY.
REQ-021 In READY with clear_in=1, the FSM SHALL go to INIT with the sweep index at 0.
REQ-022 clear_in=1 during INIT SHALL restart the sweep at index 0.
REQ-023 Lookup latency SHALL be 1 cycle: lookup_valid_in=1 in READY at cycle N gives predicted_valid_out=1 and predicted_taken_out=entry[1] at cycle N+1.
REQ-024 Otherwise predicted_valid_out=0 and predicted_taken_out=0 at N+1; this includes a lookup during INIT and a lookup in the cycle clear_in is asserted.
REQ-025 An update SHALL be accepted only when update_valid_in=1, the FSM is in READY and clear_in=0; updates at other times SHALL be dropped silently, with no BHT or counter change.
REQ-026 An accepted update SHALL apply entry = taken ? min(entry+1, 3) : max(entry-1, 0); the entry is written at the end of the cycle.
REQ-027 When a lookup and an update target the same index in the same cycle, the lookup SHALL return the pre-update value (read-before-write).
REQ-028 branch_count_out SHALL increment by 1 per accepted update; mispredict_count_out SHALL increment by 1 per accepted update with update_mispredicted_in=1.
REQ-029 Both counters SHALL wrap modulo 2^32 and SHALL NOT be cleared by clear_in.
REQ-030 All outputs SHALL be registered; there SHALL be no combinational input-to-output path.

Reset
REQ-031 While reset_n=0, the design SHALL immediately force: FSM=INIT, sweep index=0, ready_out=0, predicted_valid_out=0, predicted_taken_out=0, branch_count_out=0, mispredict_count_out=0.
REQ-032 BHT contents need not be reset; they SHALL be defined only by the sweep.
REQ-033 Reset asserted mid-sweep or mid-update SHALL abort the operation; after release, a full sweep restarts from index 0.
REQ-034 The first clock edge after reset_n deasserts SHALL write index 0.

Verification
REQ-035 Init: release reset_n, INDEX_BITS=6 -> ready_out=0 for 64 cycles and 1 from the 65th edge; a lookup at any PC then gives predicted_taken_out=0 (weak-NT).
REQ-036 Train: 2 taken updates at PC 0x100, then a lookup at 0x100 -> predicted_valid_out=1, predicted_taken_out=1; lookup at 0x200 (same index 0) -> also 1 (aliasing).
REQ-037 Saturation: 5 taken updates at 0x104 then 1 not-taken -> prediction still 1 (entry 10); a 2nd not-taken -> prediction 0.
REQ-038 Collision: entry at 0x108 = 01; lookup and taken update to 0x108 in the same cycle -> prediction 0; next-cycle lookup -> 1.
REQ-039 Drop/clear: clear_in pulsed in READY with update_valid_in=1 -> update dropped, counts unchanged, ready_out=0 for 64 cycles, all entries back to 01.
REQ-040 Counters: 10 accepted updates, 3 with update_mispredicted_in=1 -> branch_count_out=10, mispredict_count_out=3; an async reset_n pulse mid-run -> both 0 immediately.

Source files
------------

// File: rtl/rv32_branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counter BHT indexed by PC word address,
// swept to weak-not-taken after reset or clear, with 1-cycle registered lookup.
module rv32_branch_predictor #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_in,
  input  logic        lookup_valid_in,
  input  logic [31:0] lookup_pc_in,
  input  logic        update_valid_in,
  input  logic [31:0] update_pc_in,
  input  logic        update_taken_in,
  input  logic        update_mispredicted_in,
  output logic        ready_out,
  output logic        predicted_valid_out,
  output logic        predicted_taken_out,
  output logic [31:0] branch_count_out,
  output logic [31:0] mispredict_count_out
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned SWEEP_W = INDEX_BITS + 1;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state;
  logic [SWEEP_W-1:0]      sweep_idx;
  logic [1:0]              bht [ENTRIES];

  logic [INDEX_BITS-1:0]   lookup_idx;
  logic [INDEX_BITS-1:0]   update_idx;
  logic [INDEX_BITS-1:0]   sweep_wr_idx;
  logic                    sweep_done;
  logic                    sweep_wr;
  logic                    accept;
  logic                    lookup_hit;
  logic [1:0]              cur_ctr;
  logic [1:0]              nxt_ctr;

  assign lookup_idx   = lookup_pc_in[INDEX_BITS+1:2];
  assign update_idx   = update_pc_in[INDEX_BITS+1:2];
  assign sweep_wr_idx = sweep_idx[INDEX_BITS-1:0];
  assign sweep_done   = (sweep_idx == SWEEP_W'(ENTRIES));
  assign sweep_wr     = (state == INIT) && !clear_in && !sweep_done;
  assign accept       = update_valid_in && (state == READY) && !clear_in;
  assign lookup_hit   = lookup_valid_in && (state == READY) && !clear_in;
  assign cur_ctr      = bht[update_idx];

  // Index bits outside the BHT window are intentionally ignored (aliasing).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_in[31:INDEX_BITS+2], lookup_pc_in[1:0],
                            update_pc_in[31:INDEX_BITS+2], update_pc_in[1:0]};

  // Saturating counter step for the resolved branch.
  always_comb begin
    nxt_ctr = cur_ctr;
    if (update_taken_in) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
    end
  end

  // Control FSM, prediction and statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= INIT;
      sweep_idx            <= '0;
      ready_out            <= 1'b0;
      predicted_valid_out  <= 1'b0;
      predicted_taken_out  <= 1'b0;
      branch_count_out     <= '0;
      mispredict_count_out <= '0;
    end else begin
      predicted_valid_out <= lookup_hit;
      predicted_taken_out <= lookup_hit & bht[lookup_idx][1];
      if (accept) begin
        branch_count_out <= branch_count_out + 32'd1;
        if (update_mispredicted_in) mispredict_count_out <= mispredict_count_out + 32'd1;
      end
      case (state)
        INIT: begin
          if (clear_in) begin
            sweep_idx <= '0;
          end else if (sweep_done) begin
            state     <= READY;
            ready_out <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + SWEEP_W'(1);
          end
        end
        READY: begin
          if (clear_in) begin
            state     <= INIT;
            sweep_idx <= '0;
            ready_out <= 1'b0;
          end
        end
        default: begin
          state     <= INIT;
          sweep_idx <= '0;
          ready_out <= 1'b0;
        end
      endcase
    end
  end

  // BHT storage: contents defined only by the sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (sweep_wr) begin
      bht[sweep_wr_idx] <= 2'b01;
    end else if (accept) begin
      bht[update_idx] <= nxt_ctr;
    end
  end

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Bench for rv32_branch_predictor: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a behavioural table model.
module tb_rv32_branch_predictor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear_in;
  logic        lookup_valid_in;
  logic [31:0] lookup_pc_in;
  logic        update_valid_in;
  logic [31:0] update_pc_in;
  logic        update_taken_in;
  logic        update_mispredicted_in;
  logic        ready_out;
  logic        predicted_valid_out;
  logic        predicted_taken_out;
  logic [31:0] branch_count_out;
  logic [31:0] mispredict_count_out;

  rv32_branch_predictor #(.INDEX_BITS(6)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .clear_in               (clear_in),
    .lookup_valid_in        (lookup_valid_in),
    .lookup_pc_in           (lookup_pc_in),
    .update_valid_in        (update_valid_in),
    .update_pc_in           (update_pc_in),
    .update_taken_in        (update_taken_in),
    .update_mispredicted_in (update_mispredicted_in),
    .ready_out              (ready_out),
    .predicted_valid_out    (predicted_valid_out),
    .predicted_taken_out    (predicted_taken_out),
    .branch_count_out       (branch_count_out),
    .mispredict_count_out   (mispredict_count_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: table of counter values 0..3 plus an init countdown.
  int          m_bht [64];
  bit          m_ready;
  int          m_init_done;
  bit          m_pv;
  bit          m_pt;
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready     = 1'b0;
    m_init_done = 0;
    m_pv        = 1'b0;
    m_pt        = 1'b0;
    m_bc        = '0;
    m_mc        = '0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held during the cycle.
  task automatic model_step();
    int li;
    int ui;
    li   = int'((lookup_pc_in >> 2) & 32'h3F);
    ui   = int'((update_pc_in >> 2) & 32'h3F);
    m_pv = m_ready && lookup_valid_in && !clear_in;
    m_pt = m_pv && (m_bht[li] >= 2);
    if (m_ready) begin
      if (clear_in) begin
        m_ready     = 1'b0;
        m_init_done = 0;
      end else if (update_valid_in) begin
        m_bc = m_bc + 32'd1;
        if (update_mispredicted_in) m_mc = m_mc + 32'd1;
        if (update_taken_in) m_bht[ui] = (m_bht[ui] == 3) ? 3 : m_bht[ui] + 1;
        else                 m_bht[ui] = (m_bht[ui] == 0) ? 0 : m_bht[ui] - 1;
      end
    end else if (clear_in) begin
      m_init_done = 0;
    end else if (m_init_done == 64) begin
      m_ready = 1'b1;
    end else begin
      m_bht[m_init_done] = 1;
      m_init_done++;
    end
  endtask

  task automatic compare_model();
    chk("ready",            {31'd0, ready_out},           {31'd0, m_ready});
    chk("pred_valid",       {31'd0, predicted_valid_out}, {31'd0, m_pv});
    chk("pred_taken",       {31'd0, predicted_taken_out}, {31'd0, m_pt});
    chk("branch_count",     branch_count_out,             m_bc);
    chk("mispredict_count", mispredict_count_out,         m_mc);
  endtask

  // Inputs change just after the falling edge; outputs are checked on the next falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic set_in(input bit clr, input bit lv, input logic [31:0] lpc,
                        input bit uv, input logic [31:0] upc, input bit tk, input bit mis);
    clear_in               = clr;
    lookup_valid_in        = lv;
    lookup_pc_in           = lpc;
    update_valid_in        = uv;
    update_pc_in           = upc;
    update_taken_in        = tk;
    update_mispredicted_in = mis;
  endtask

  task automatic idle();
    set_in(0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  task automatic lookup_at(input logic [31:0] pc);
    set_in(0, 1, pc, 0, 32'h0, 0, 0);
  endtask

  task automatic update_at(input logic [31:0] pc, input bit tk, input bit mis);
    set_in(0, 0, 32'h0, 1, pc, tk, mis);
  endtask

  task automatic random_inputs(input int clear_odds);
    set_in(($urandom_range(0, clear_odds - 1) == 0), $urandom_range(0, 1), $urandom,
           $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  // Asynchronous reset pulse in mid-cycle with whatever inputs are currently applied.
  task automatic async_reset_pulse(input string tag);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, "_ready"},  {31'd0, ready_out},           32'd0);
    chk({tag, "_pvalid"}, {31'd0, predicted_valid_out}, 32'd0);
    chk({tag, "_bcount"}, branch_count_out,             32'd0);
    chk({tag, "_mcount"}, mispredict_count_out,         32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_bht[i] = 0;
    reset_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready",  {31'd0, ready_out},           32'd0);
    chk("reset_pvalid", {31'd0, predicted_valid_out}, 32'd0);
    chk("reset_ptaken", {31'd0, predicted_taken_out}, 32'd0);
    chk("reset_bcount", branch_count_out,             32'd0);
    chk("reset_mcount", mispredict_count_out,         32'd0);
    reset_n = 1'b1;

    // Sweep: not ready for 64 edges, ready on the 65th.
    for (int i = 0; i < 64; i++) begin
      cycle();
      chk("init_not_ready", {31'd0, ready_out}, 32'd0);
    end
    cycle();
    chk("init_ready", {31'd0, ready_out}, 32'd1);

    lookup_at($urandom);
    cycle();
    chk("init_lookup_valid", {31'd0, predicted_valid_out}, 32'd1);
    chk("init_lookup_taken", {31'd0, predicted_taken_out}, 32'd0);

    // Train index 0 and observe aliasing.
    update_at(32'h100, 1, 1); cycle();
    update_at(32'h100, 1, 0); cycle();
    lookup_at(32'h100); cycle();
    chk("train_valid", {31'd0, predicted_valid_out}, 32'd1);
    chk("train_taken", {31'd0, predicted_taken_out}, 32'd1);
    lookup_at(32'h200); cycle();
    chk("alias_taken", {31'd0, predicted_taken_out}, 32'd1);

    // Saturation at index 1.
    for (int i = 0; i < 5; i++) begin
      update_at(32'h104, 1, 0); cycle();
    end
    update_at(32'h104, 0, 1); cycle();
    lookup_at(32'h104); cycle();
    chk("sat_one_nt", {31'd0, predicted_taken_out}, 32'd1);
    update_at(32'h104, 0, 0); cycle();
    lookup_at(32'h104); cycle();
    chk("sat_two_nt", {31'd0, predicted_taken_out}, 32'd0);

    // Same-cycle lookup and update: read-before-write.
    set_in(0, 1, 32'h108, 1, 32'h108, 1, 1); cycle();
    chk("collide_old", {31'd0, predicted_taken_out}, 32'd0);
    lookup_at(32'h108); cycle();
    chk("collide_new", {31'd0, predicted_taken_out}, 32'd1);
    chk("counts_branch",     branch_count_out,     32'd10);
    chk("counts_mispredict", mispredict_count_out, 32'd3);

    // Clear with a concurrent update: update dropped, full re-sweep.
    set_in(1, 1, 32'h100, 1, 32'h100, 1, 1); cycle();
    chk("clear_ready",   {31'd0, ready_out},           32'd0);
    chk("clear_pvalid",  {31'd0, predicted_valid_out}, 32'd0);
    chk("clear_bcount",  branch_count_out,             32'd10);
    chk("clear_mcount",  mispredict_count_out,         32'd3);
    idle();
    for (int i = 0; i < 63; i++) begin
      cycle();
      chk("clear_not_ready", {31'd0, ready_out}, 32'd0);
    end
    cycle();
    cycle();
    chk("clear_ready_again", {31'd0, ready_out}, 32'd1);
    lookup_at(32'h100); cycle();
    chk("clear_entry0", {31'd0, predicted_taken_out}, 32'd0);
    lookup_at(32'h108); cycle();
    chk("clear_entry2", {31'd0, predicted_taken_out}, 32'd0);
    update_at(32'h10C, 0, 0); cycle();
    chk("post_clear_bcount", branch_count_out,     32'd11);
    chk("post_clear_mcount", mispredict_count_out, 32'd3);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      random_inputs(60);
      cycle();
    end

    // Reset during an update, then again mid-sweep.
    update_at(32'h104, 1, 1);
    async_reset_pulse("rst_mid_update");
    for (int i = 0; i < 30; i++) begin
      random_inputs(1000);
      cycle();
    end
    async_reset_pulse("rst_mid_sweep");
    for (int i = 0; i < 300; i++) begin
      random_inputs(80);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
